// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg
// Shared definitions for the ID/EX stage: instruction op classes, the ALU
// control codes consumed by the ALU, and the operand forwarding selector.
package id_ex_stage_pkg;

  typedef enum logic [2:0] {
    CLS_R_ALU  = 3'd0,
    CLS_I_ALU  = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_JALR   = 3'd4,
    CLS_BRANCH = 3'd5,
    CLS_JAL    = 3'd6
  } op_class_e;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;
  localparam logic [3:0] ALU_BNE = 4'd9;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  // Classes that write a destination register (before the rd != x0 check).
  function automatic logic writes_rd(input op_class_e c);
    return (c == CLS_R_ALU) || (c == CLS_I_ALU) || (c == CLS_LOAD) ||
           (c == CLS_JALR)  || (c == CLS_JAL);
  endfunction

  // EX/MEM wins over MEM/WB; x0 never forwards.
  function automatic fwd_sel_e fwd_select(input logic [4:0] rs,
                                          input logic       em_we,
                                          input logic [4:0] em_rd,
                                          input logic       mw_we,
                                          input logic [4:0] mw_rd);
    if (rs == 5'd0)                 return FWD_REG;
    else if (em_we && em_rd == rs)  return FWD_EXMEM;
    else if (mw_we && mw_rd == rs)  return FWD_MEMWB;
    else                            return FWD_REG;
  endfunction

endpackage

// File: rtl/id_ex_stage_alu_ctrl_dec.sv
// alu_ctrl_dec
// Combinational decode of op class / funct3 / instr[30] into the 4-bit ALU
// control code.
//   i_class  : op class
//   i_funct3 : instr[14:12]
//   i_b30    : instr[30]
//   o_code   : ALU control code
module alu_ctrl_dec
  import id_ex_stage_pkg::*;
(
  input  op_class_e  i_class,
  input  logic [2:0] i_funct3,
  input  logic       i_b30,
  output logic [3:0] o_code
);

  always_comb begin
    o_code = ALU_ADD;
    case (i_class)
      CLS_R_ALU, CLS_I_ALU: begin
        case (i_funct3)
          // instr[30] on ADDI is immediate data, so SUB exists only for R-type
          3'b000: o_code = (i_class == CLS_R_ALU && i_b30) ? ALU_SUB : ALU_ADD;
          3'b111: o_code = ALU_AND;
          3'b110: o_code = ALU_OR;
          3'b010: o_code = ALU_SLT;
          3'b100: o_code = ALU_XOR;
          3'b001: o_code = ALU_SLL;
          3'b101: o_code = i_b30 ? ALU_SRA : ALU_SRL;
          default: o_code = ALU_ADD;
        endcase
      end
      CLS_BRANCH: begin
        case (i_funct3)
          3'b000:  o_code = ALU_XOR;   // BEQ: zero result means equal
          3'b001:  o_code = ALU_BNE;
          default: o_code = ALU_ADD;
        endcase
      end
      default: o_code = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register in front of the ALU. Registers the decoded
// instruction, forwards operands from EX/MEM and MEM/WB, selects the ALU
// operands and raises a one-cycle load-use stall toward IF/ID.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   hold_i, flush_i        : global freeze, redirect kill
//   id_*                   : decoded instruction from ID
//   exmem_*, memwb_*       : forwarding sources
//   stall_o                : load-use hazard, IF/ID must hold
//   ex_*, alu_*            : EX-side control, ALU code and operands
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = 32
)(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            hold_i,
  input  logic            flush_i,
  input  logic            id_valid_i,
  input  op_class_e       id_class_i,
  input  logic [2:0]      id_funct3_i,
  input  logic            id_b30_i,
  input  logic [4:0]      id_rs1_i,
  input  logic [4:0]      id_rs2_i,
  input  logic [4:0]      id_rd_i,
  input  logic            id_use_rs1_i,
  input  logic            id_use_rs2_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic            exmem_regwrite_i,
  input  logic [4:0]      exmem_rd_i,
  input  logic [XLEN-1:0] exmem_data_i,
  input  logic            memwb_regwrite_i,
  input  logic [4:0]      memwb_rd_i,
  input  logic [XLEN-1:0] memwb_data_i,
  output logic            stall_o,
  output logic            ex_valid_o,
  output logic            ex_regwrite_o,
  output logic            ex_memread_o,
  output logic            ex_memwrite_o,
  output logic [4:0]      ex_rd_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [3:0]      alu_ctrl_o,
  output logic [XLEN-1:0] alu_data1_o,
  output logic [XLEN-1:0] alu_data2_o,
  output logic [XLEN-1:0] ex_store_data_o
);

  logic            r_valid, r_regwrite, r_memread, r_memwrite, r_op2_reg;
  logic [4:0]      r_rd, r_rs1, r_rs2;
  logic [3:0]      r_alu_ctrl;
  logic [XLEN-1:0] r_pc, r_rs1_data, r_rs2_data, r_imm;

  logic [3:0]      w_alu_ctrl;
  logic            w_stall, w_clear;
  fwd_sel_e        w_sel1, w_sel2;
  logic [XLEN-1:0] w_fwd1, w_fwd2;

  alu_ctrl_dec u_alu_ctrl_dec (
    .i_class  (id_class_i),
    .i_funct3 (id_funct3_i),
    .i_b30    (id_b30_i),
    .o_code   (w_alu_ctrl)
  );

  // Not gated by hold: the hazard is reported even while frozen, but hold
  // keeps the register contents, so it re-evaluates after release.
  assign w_stall = r_valid && r_memread && (r_rd != 5'd0) && id_valid_i &&
                   ((id_use_rs1_i && id_rs1_i == r_rd) ||
                    (id_use_rs2_i && id_rs2_i == r_rd));

  // Reset, flush (even under hold) and an unfrozen stall all load a bubble.
  assign w_clear = rst_i || flush_i || (!hold_i && w_stall);

  always_ff @(posedge clk_i) begin
    if (w_clear) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_op2_reg  <= 1'b0;
      r_rd       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_alu_ctrl <= '0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
    end else if (!hold_i) begin
      r_valid    <= id_valid_i;
      r_regwrite <= id_valid_i && writes_rd(id_class_i) && (id_rd_i != 5'd0);
      r_memread  <= id_valid_i && (id_class_i == CLS_LOAD);
      r_memwrite <= id_valid_i && (id_class_i == CLS_STORE);
      r_op2_reg  <= (id_class_i == CLS_R_ALU) || (id_class_i == CLS_BRANCH);
      r_rd       <= id_rd_i;
      r_rs1      <= id_rs1_i;
      r_rs2      <= id_rs2_i;
      r_alu_ctrl <= w_alu_ctrl;
      r_pc       <= id_pc_i;
      r_rs1_data <= id_rs1_data_i;
      r_rs2_data <= id_rs2_data_i;
      r_imm      <= id_imm_i;
    end
  end

  assign w_sel1 = fwd_select(r_rs1, exmem_regwrite_i, exmem_rd_i,
                             memwb_regwrite_i, memwb_rd_i);
  assign w_sel2 = fwd_select(r_rs2, exmem_regwrite_i, exmem_rd_i,
                             memwb_regwrite_i, memwb_rd_i);

  always_comb begin
    w_fwd1 = r_rs1_data;
    case (w_sel1)
      FWD_EXMEM: w_fwd1 = exmem_data_i;
      FWD_MEMWB: w_fwd1 = memwb_data_i;
      default:   w_fwd1 = r_rs1_data;
    endcase
    w_fwd2 = r_rs2_data;
    case (w_sel2)
      FWD_EXMEM: w_fwd2 = exmem_data_i;
      FWD_MEMWB: w_fwd2 = memwb_data_i;
      default:   w_fwd2 = r_rs2_data;
    endcase
  end

  assign stall_o         = w_stall;
  assign ex_valid_o      = r_valid;
  assign ex_regwrite_o   = r_regwrite;
  assign ex_memread_o    = r_memread;
  assign ex_memwrite_o   = r_memwrite;
  assign ex_rd_o         = r_rd;
  assign ex_pc_o         = r_pc;
  assign alu_ctrl_o      = r_alu_ctrl;
  assign alu_data1_o     = w_fwd1;
  assign alu_data2_o     = r_op2_reg ? w_fwd2 : r_imm;
  assign ex_store_data_o = w_fwd2;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
// Directed bench for id_ex_stage. Each step drives ID (and the forwarding
// sources seen during the following EX cycle), pushes the expected EX view
// onto a scoreboard, and pops/compares it one cycle later.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i, hold_i, flush_i;
  logic        id_valid_i, id_b30_i, id_use_rs1_i, id_use_rs2_i;
  op_class_e   id_class_i;
  logic [2:0]  id_funct3_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i, id_pc_i;
  logic        exmem_regwrite_i, memwb_regwrite_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic [31:0] exmem_data_i, memwb_data_i;
  logic        stall_o, ex_valid_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o;
  logic [4:0]  ex_rd_o;
  logic [31:0] ex_pc_o, alu_data1_o, alu_data2_o, ex_store_data_o;
  logic [3:0]  alu_ctrl_o;

  typedef struct {
    logic        v, rw, mr, mw;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [3:0]  ctrl;
    logic [31:0] d1, d2, sd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [2:0] tbl_f3[4]   = '{3'd7, 3'd6, 3'd2, 3'd1};
  logic [3:0] tbl_code[4] = '{4'd2, 4'd3, 4'd4, 4'd6};

  always #5 clk_i = ~clk_i;

  id_ex_stage #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_class_i(id_class_i), .id_funct3_i(id_funct3_i),
    .id_b30_i(id_b30_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_pc_i(id_pc_i),
    .exmem_regwrite_i(exmem_regwrite_i), .exmem_rd_i(exmem_rd_i), .exmem_data_i(exmem_data_i),
    .memwb_regwrite_i(memwb_regwrite_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
    .stall_o(stall_o), .ex_valid_o(ex_valid_o), .ex_regwrite_o(ex_regwrite_o),
    .ex_memread_o(ex_memread_o), .ex_memwrite_o(ex_memwrite_o), .ex_rd_o(ex_rd_o),
    .ex_pc_o(ex_pc_o), .alu_ctrl_o(alu_ctrl_o), .alu_data1_o(alu_data1_o),
    .alu_data2_o(alu_data2_o), .ex_store_data_o(ex_store_data_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_id(input logic v, input op_class_e c, input logic [2:0] f3,
                        input logic b30, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic u1, input logic u2,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [31:0] pc);
    id_valid_i = v;     id_class_i = c;       id_funct3_i = f3;  id_b30_i = b30;
    id_rs1_i = rs1;     id_rs2_i = rs2;       id_rd_i = rd;
    id_use_rs1_i = u1;  id_use_rs2_i = u2;
    id_rs1_data_i = d1; id_rs2_data_i = d2;   id_imm_i = imm;    id_pc_i = pc;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] ed,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] md);
    exmem_regwrite_i = ew; exmem_rd_i = erd; exmem_data_i = ed;
    memwb_regwrite_i = mw; memwb_rd_i = mrd; memwb_data_i = md;
  endtask

  task automatic push(input logic v, input logic rw, input logic mr, input logic mw,
                      input logic [4:0] rd, input logic [31:0] pc, input logic [3:0] ctrl,
                      input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] sd);
    exp_t e;
    e.v = v; e.rw = rw; e.mr = mr; e.mw = mw; e.rd = rd; e.pc = pc;
    e.ctrl = ctrl; e.d1 = d1; e.d2 = d2; e.sd = sd;
    sb.push_back(e);
  endtask

  task automatic check_ex(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", name);
    end else begin
      e = sb.pop_front();
      chk({name, ".valid"},    ex_valid_o,      e.v);
      chk({name, ".regwrite"}, ex_regwrite_o,   e.rw);
      chk({name, ".memread"},  ex_memread_o,    e.mr);
      chk({name, ".memwrite"}, ex_memwrite_o,   e.mw);
      chk({name, ".rd"},       ex_rd_o,         e.rd);
      chk({name, ".pc"},       ex_pc_o,         e.pc);
      chk({name, ".ctrl"},     alu_ctrl_o,      e.ctrl);
      chk({name, ".data1"},    alu_data1_o,     e.d1);
      chk({name, ".data2"},    alu_data2_o,     e.d2);
      chk({name, ".store"},    ex_store_data_o, e.sd);
    end
  endtask

  // Clock edge, then present the EX-cycle forwarding sources, then compare.
  task automatic cycle(input string name,
                       input logic ew, input logic [4:0] erd, input logic [31:0] ed,
                       input logic mw, input logic [4:0] mrd, input logic [31:0] md);
    @(posedge clk_i);
    #1;
    set_fwd(ew, erd, ed, mw, mrd, md);
    #1;
    check_ex(name);
  endtask

  initial begin
    rst_i = 1'b1; hold_i = 1'b0; flush_i = 1'b0;
    set_id(0, CLS_R_ALU, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.stall", stall_o, 1'b0);
    rst_i = 1'b0;

    // SUB x3, x1, x2
    set_id(1, CLS_R_ALU, 3'b000, 1, 1, 2, 3, 1, 1, 32'd10, 32'd3, 0, 32'h100);
    #1 chk("sub.stall", stall_o, 1'b0);
    push(1, 1, 0, 0, 3, 32'h100, ALU_SUB, 32'd10, 32'd3, 32'd3);
    cycle("sub", 0, 0, 0, 0, 0, 0);

    // ADDI x5, x1, 7 (instr[30] set) with both stages writing x1
    set_id(1, CLS_I_ALU, 3'b000, 1, 1, 7, 5, 1, 0, 32'd1, 32'h55, 32'd7, 32'h104);
    push(1, 1, 0, 0, 5, 32'h104, ALU_ADD, 32'd100, 32'd7, 32'h55);
    cycle("addi_fwd", 1, 1, 32'd100, 1, 1, 32'd50);

    // XOR x0, x4, x4: MEM/WB-only hit, no regwrite to x0
    set_id(1, CLS_R_ALU, 3'b100, 0, 4, 4, 0, 1, 1, 32'd1, 32'd1, 0, 32'h108);
    push(1, 0, 0, 0, 0, 32'h108, ALU_XOR, 32'h77, 32'h77, 32'h77);
    cycle("xor_memwb", 1, 9, 32'h99, 1, 4, 32'h77);

    // ADD x8, x0, x0 while both stages claim to write x0
    set_id(1, CLS_R_ALU, 3'b000, 0, 0, 0, 8, 1, 1, 0, 0, 0, 32'h10C);
    push(1, 1, 0, 0, 8, 32'h10C, ALU_ADD, 0, 0, 0);
    cycle("x0_fwd", 1, 0, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF);

    // LW x6, 4(x2) then ADD x7, x6, x2
    set_id(1, CLS_LOAD, 3'b010, 0, 2, 0, 6, 1, 0, 32'h1000, 0, 32'd4, 32'h110);
    push(1, 1, 1, 0, 6, 32'h110, ALU_ADD, 32'h1000, 32'd4, 0);
    cycle("lw", 0, 0, 0, 0, 0, 0);
    set_id(1, CLS_R_ALU, 3'b000, 0, 6, 2, 7, 1, 1, 32'hDEAD, 32'd20, 0, 32'h114);
    #1 chk("loaduse.stall", stall_o, 1'b1);
    push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("loaduse_bubble", 0, 0, 0, 0, 0, 0);
    chk("loaduse.stall_drop", stall_o, 1'b0);
    push(1, 1, 0, 0, 7, 32'h114, ALU_ADD, 32'hCAFE, 32'd20, 32'd20);
    cycle("add_after_load", 1, 6, 32'hCAFE, 0, 0, 0);

    // Branches compare register operands
    set_id(1, CLS_BRANCH, 3'b001, 0, 2, 3, 0, 1, 1, 32'd5, 32'd6, 32'h40, 32'h118);
    push(1, 0, 0, 0, 0, 32'h118, ALU_BNE, 32'd5, 32'd6, 32'd6);
    cycle("bne", 0, 0, 0, 0, 0, 0);
    set_id(1, CLS_BRANCH, 3'b000, 0, 2, 3, 0, 1, 1, 32'd5, 32'd6, 32'h40, 32'h11C);
    push(1, 0, 0, 0, 0, 32'h11C, ALU_XOR, 32'd5, 32'd6, 32'd6);
    cycle("beq", 0, 0, 0, 0, 0, 0);

    // Shifts
    set_id(1, CLS_R_ALU, 3'b101, 1, 1, 2, 10, 1, 1, 32'h8000_0000, 32'd4, 0, 32'h120);
    push(1, 1, 0, 0, 10, 32'h120, ALU_SRA, 32'h8000_0000, 32'd4, 32'd4);
    cycle("sra", 0, 0, 0, 0, 0, 0);
    set_id(1, CLS_I_ALU, 3'b101, 0, 1, 0, 11, 1, 0, 32'd8, 32'h12, 32'd2, 32'h124);
    push(1, 1, 0, 0, 11, 32'h124, ALU_SRL, 32'd8, 32'd2, 32'h12);
    cycle("srli", 0, 0, 0, 0, 0, 0);

    // SW x2, 8(x1)
    set_id(1, CLS_STORE, 3'b010, 0, 1, 2, 0, 1, 1, 32'h200, 32'h33, 32'd8, 32'h128);
    push(1, 0, 0, 1, 0, 32'h128, ALU_ADD, 32'h200, 32'd8, 32'h33);
    cycle("sw", 0, 0, 0, 0, 0, 0);

    // JAL x1
    set_id(1, CLS_JAL, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0, 32'h800, 32'h12C);
    push(1, 1, 0, 0, 1, 32'h12C, ALU_ADD, 0, 32'h800, 0);
    cycle("jal", 0, 0, 0, 0, 0, 0);

    // Remaining R-type functions
    for (int i = 0; i < 4; i++) begin
      set_id(1, CLS_R_ALU, tbl_f3[i], 0, 1, 2, 13, 1, 1, 32'd3, 32'd5, 0, 32'h130 + 32'(4 * i));
      push(1, 1, 0, 0, 13, 32'h130 + 32'(4 * i), tbl_code[i], 32'd3, 32'd5, 32'd5);
      cycle("rtype_tbl", 0, 0, 0, 0, 0, 0);
    end

    // Flush kills the captured instruction
    set_id(1, CLS_R_ALU, 3'b000, 0, 1, 2, 3, 1, 1, 32'd1, 32'd2, 0, 32'h140);
    flush_i = 1'b1;
    push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("flush", 0, 0, 0, 0, 0, 0);
    flush_i = 1'b0;

    // Flush together with a load-use stall
    set_id(1, CLS_LOAD, 3'b010, 0, 2, 0, 6, 1, 0, 32'h1000, 0, 32'd4, 32'h144);
    push(1, 1, 1, 0, 6, 32'h144, ALU_ADD, 32'h1000, 32'd4, 0);
    cycle("lw2", 0, 0, 0, 0, 0, 0);
    set_id(1, CLS_R_ALU, 3'b000, 0, 2, 6, 7, 1, 1, 32'd1, 32'd2, 0, 32'h148);
    flush_i = 1'b1;
    #1 chk("flush_stall.stall", stall_o, 1'b1);
    push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("flush_stall", 0, 0, 0, 0, 0, 0);
    flush_i = 1'b0;

    // Hold keeps a load in EX while a dependent instruction waits in ID
    set_id(1, CLS_LOAD, 3'b010, 0, 2, 0, 9, 1, 0, 32'h2000, 0, 32'h10, 32'h150);
    push(1, 1, 1, 0, 9, 32'h150, ALU_ADD, 32'h2000, 32'h10, 0);
    cycle("lw_hold", 0, 0, 0, 0, 0, 0);
    set_id(1, CLS_R_ALU, 3'b000, 0, 9, 3, 14, 1, 1, 32'd7, 32'd8, 0, 32'h154);
    hold_i = 1'b1;
    #1 chk("hold.stall", stall_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      push(1, 1, 1, 0, 9, 32'h150, ALU_ADD, 32'h2000, 32'h10, 0);
      cycle("hold", 0, 0, 0, 0, 0, 0);
    end
    rst_i = 1'b1;
    push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("rst_in_hold", 0, 0, 0, 0, 0, 0);
    chk("rst_in_hold.stall", stall_o, 1'b0);
    rst_i = 1'b0;
    hold_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
